// File: rtl/pipelined_adder.sv
// Purpose : PARALLELISM-bit add/subtract split into NUM_STAGES equal segments with carry registered between stages.
// Latency : NUM_STAGES cycles from acceptance to out_valid, one result per cycle.
// Backpr. : out_valid & ~out_ready freezes every stage (bubbles included); in_ready = ~stall.
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   in_valid/in_ready                 operand handshake
//   add1, add0, carry_in, sub         operands A and B; sub=1 computes A + ~B + 1 (carry_in ignored)
//   out_valid/out_ready               result handshake
//   sum, carry_out, overflow          result mod 2^PARALLELISM, MSB carry (1 = no borrow on sub), signed overflow
module pipelined_adder #(
  parameter int PARALLELISM = 32,
  parameter int NUM_STAGES  = 4,
  parameter int ARCH_TYPE   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PARALLELISM-1:0] add1,
  input  logic [PARALLELISM-1:0] add0,
  input  logic                   carry_in,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PARALLELISM-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow
);

  // Guarded so that an illegal stage count reports the error below rather
  // than a divide-by-zero during elaboration.
  localparam int NS = (NUM_STAGES >= 1) ? NUM_STAGES : 1;
  localparam int W  = PARALLELISM / NS;

  if (NUM_STAGES < 1 || (PARALLELISM % NS) != 0) begin : g_bad_params
    $error("pipelined_adder: PARALLELISM must be divisible by NUM_STAGES and NUM_STAGES >= 1");
  end

  logic stall;
  logic advance;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // Transaction state entering each stage. Every stage carries the full
  // operands (upper slices not yet consumed) and the partial sum (lower
  // slices already produced), so each stage holds a complete transaction.
  logic [PARALLELISM-1:0] a_in [NS];
  logic [PARALLELISM-1:0] b_in [NS];
  logic [PARALLELISM-1:0] s_in [NS];
  logic                   c_in [NS];
  logic                   v_in [NS];

  // B is inverted once at acceptance; the +1 of the two's complement rides
  // in as the stage-0 carry.
  assign a_in[0] = add1;
  assign b_in[0] = sub ? ~add0 : add0;
  assign s_in[0] = '0;
  assign c_in[0] = sub | carry_in;
  assign v_in[0] = in_valid;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic [W-1:0]           seg_a;
    logic [W-1:0]           seg_b;
    logic [W-1:0]           seg_s;
    logic                   seg_c;
    logic [PARALLELISM-1:0] s_nxt;

    assign seg_a = a_in[k][k*W +: W];
    assign seg_b = b_in[k][k*W +: W];

    if (ARCH_TYPE == 1) begin : g_ripple
      always_comb begin : ripple
        logic c;
        c     = c_in[k];
        seg_s = '0;
        for (int i = 0; i < W; i++) begin
          seg_s[i] = seg_a[i] ^ seg_b[i] ^ c;
          c        = (seg_a[i] & seg_b[i]) | (c & (seg_a[i] ^ seg_b[i]));
        end
        seg_c = c;
      end
    end else begin : g_behav
      assign {seg_c, seg_s} = {1'b0, seg_a} + {1'b0, seg_b} + {{W{1'b0}}, c_in[k]};
    end

    // Splice this stage's segment into the partial sum.
    always_comb begin
      s_nxt            = s_in[k];
      s_nxt[k*W +: W]  = seg_s;
    end

    if (k < NS - 1) begin : g_mid
      logic [PARALLELISM-1:0] a_q;
      logic [PARALLELISM-1:0] b_q;
      logic [PARALLELISM-1:0] s_q;
      logic                   c_q;
      logic                   v_q;

      // Bubbles advance their valid bit but leave the data registers alone.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_in[k];
          if (v_in[k]) begin
            a_q <= a_in[k];
            b_q <= b_in[k];
            s_q <= s_nxt;
            c_q <= seg_c;
          end
        end
      end

      assign a_in[k+1] = a_q;
      assign b_in[k+1] = b_q;
      assign s_in[k+1] = s_q;
      assign c_in[k+1] = c_q;
      assign v_in[k+1] = v_q;
    end else begin : g_last
      // Result registers only load on a valid transaction, so they keep the
      // last result while out_valid is low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
        end else if (advance) begin
          out_valid <= v_in[k];
          if (v_in[k]) begin
            sum       <= s_nxt;
            carry_out <= seg_c;
            overflow  <= (a_in[k][PARALLELISM-1] == b_in[k][PARALLELISM-1]) &
                         (s_nxt[PARALLELISM-1] != a_in[k][PARALLELISM-1]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Index 0: 4 stages behavioural, 1: 8 stages ripple, 2: 1 stage ripple.
  logic [2:0]       iv, ir, ov, ordy, ci, sb, co, of;
  logic [2:0][31:0] a, b, s;

  pipelined_adder #(.PARALLELISM(32), .NUM_STAGES(4), .ARCH_TYPE(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .add1(a[0]), .add0(b[0]), .carry_in(ci[0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s[0]),
    .carry_out(co[0]), .overflow(of[0]));

  pipelined_adder #(.PARALLELISM(32), .NUM_STAGES(8), .ARCH_TYPE(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .add1(a[1]), .add0(b[1]), .carry_in(ci[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s[1]),
    .carry_out(co[1]), .overflow(of[1]));

  pipelined_adder #(.PARALLELISM(32), .NUM_STAGES(1), .ARCH_TYPE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .add1(a[2]), .add0(b[2]), .carry_in(ci[2]), .sub(sb[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s[2]),
    .carry_out(co[2]), .overflow(of[2]));

  // Expected results per DUT, in acceptance order: {overflow, carry_out, sum}.
  logic [33:0] sbm [3][64];
  int          wp  [3];
  int          rp  [3];

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 8 : 1);
  endfunction

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic m);
    logic [31:0] yy;
    logic [32:0] f;
    logic        v;
    yy = m ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {32'd0, (m | c)};
    v  = (x[31] == yy[31]) && (f[31] != x[31]);
    return {v, f[32], f[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge: retire an output transfer, record an input accept.
  task automatic score(input int d, input string tag);
    if (ov[d] && ordy[d]) begin
      if (rp[d] == wp[d]) begin
        chk({tag, " spurious out_valid"}, ov[d], 1'b0);
      end else begin
        chk({tag, " result"}, {of[d], co[d], s[d]}, sbm[d][rp[d] & 63]);
        rp[d]++;
      end
    end
    if (iv[d] && ir[d]) begin
      sbm[d][wp[d] & 63] = model(a[d], b[d], ci[d], sb[d]);
      wp[d]++;
    end
  endtask

  // One isolated transaction with out_ready high: checks accept, latency, result.
  task automatic send_one(input int d, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic m, input logic [33:0] exp,
                          input string tag);
    int cnt;
    iv[d] = 1'b1; a[d] = x; b[d] = y; ci[d] = c; sb[d] = m; ordy[d] = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready"}, ir[d], 1'b1);
    step;
    iv[d] = 1'b0;
    cnt   = 1;
    while (!ov[d] && cnt < 20) begin
      step;
      cnt++;
    end
    chk({tag, " latency"}, cnt, lat_of(d));
    chk({tag, " result"}, {of[d], co[d], s[d]}, exp);
  endtask

  initial begin
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [33:0] held;
    logic        seen;
    int          idx;
    logic [31:0] ra, rb;
    logic        rc, rs, rv;

    rst_n = 1'b0;
    iv = '0; ordy = '1; ci = '0; sb = '0; a = '0; b = '0;
    held = '0;
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0;
      rp[d] = 0;
    end
    repeat (3) step;

    // Reset state.
    for (int d = 0; d < 3; d++) begin
      chk("reset out_valid", ov[d], 1'b0);
      chk("reset sum", s[d], 32'h0);
      chk("reset flags", {of[d], co[d]}, 2'b00);
      chk("reset in_ready", ir[d], 1'b1);
    end
    rst_n = 1'b1;
    step;

    // Directed arithmetic on the 4-stage instance.
    send_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, "carry chain");
    send_one(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, "ovf add");
    send_one(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, "ovf sub");
    send_one(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, "sub borrow");
    send_one(0, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0002}, "sub no borrow");
    send_one(0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0001_0000}, "carry_in");
    step;

    // Backpressure: 8 back-to-back transactions, out_ready low in cycles 5..8.
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom % 2); vs[i] = 1'($urandom % 2);
    end
    idx = 0;
    for (int c = 0; c < 40 && rp[0] < wp[0] + (8 - idx); c++) begin
      iv[0]   = (idx < 8);
      a[0]    = va[idx & 7];
      b[0]    = vb[idx & 7];
      ci[0]   = vc[idx & 7];
      sb[0]   = vs[idx & 7];
      ordy[0] = !(c >= 5 && c <= 8);
      @(negedge clk);
      chk("bp in_ready", ir[0], !(c >= 5 && c <= 8));
      if (c == 5) held = {of[0], co[0], s[0]};
      if (c > 5 && c <= 8) chk("bp hold", {of[0], co[0], s[0]}, held);
      if (iv[0] && ir[0]) idx++;
      score(0, "bp");
      step;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("bp accepted", idx, 8);
    chk("bp delivered", rp[0], 8);

    // Reset with three transactions in flight.
    step;
    iv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[0] = 32'h100 * (i + 1); b[0] = 32'h3; ci[0] = 1'b0; sb[0] = 1'b0;
      step;
    end
    iv[0]  = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst out_valid", ov[0], 1'b0);
    chk("midrst sum", s[0], 32'h0);
    chk("midrst flags", {of[0], co[0]}, 2'b00);
    step;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      step;
      seen = seen | ov[0];
    end
    chk("midrst stale output", seen, 1'b0);
    send_one(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {2'b00, 32'h2345_6789}, "post reset");
    step;

    // Latency of the 8-stage and 1-stage configurations.
    send_one(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {2'b01, 32'h0000_0000}, "s8 carry");
    step;
    send_one(1, 32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, {2'b00, 32'hFFFF_FFFA}, "s8 sub");
    step;
    send_one(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {2'b10, 32'h8000_0000}, "s1 ovf");
    step;
    send_one(2, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, {2'b11, 32'h0000_0001}, "s1 neg ovf");
    step;

    // Random sweep with random in_valid / out_ready on both extra configs.
    for (int d = 1; d < 3; d++) begin
      wp[d] = 0;
      rp[d] = 0;
    end
    for (int c = 0; c < 1400; c++) begin
      ra = $urandom; rb = $urandom;
      if (($urandom % 8) == 0) ra = 32'hFFFF_FFFF;
      if (($urandom % 8) == 0) rb = 32'h8000_0000;
      rc = 1'($urandom % 2); rs = 1'($urandom % 2); rv = (($urandom % 4) != 0);
      for (int d = 1; d < 3; d++) begin
        iv[d] = rv; a[d] = ra; b[d] = rb; ci[d] = rc; sb[d] = rs;
        ordy[d] = (($urandom % 3) != 0);
      end
      @(negedge clk);
      score(1, "sweep s8");
      score(2, "sweep s1");
      step;
    end
    for (int d = 1; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      score(1, "drain s8");
      score(2, "drain s1");
      step;
    end
    chk("sweep s8 all delivered", rp[1], wp[1]);
    chk("sweep s1 all delivered", rp[2], wp[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the team's combinational adder. Splits a PARALLELISM-bit add/subtract into NUM_STAGES equal segments, one segment per pipeline stage, with the carry registered between stages. Reports carry-out and signed overflow. Uses a valid/ready handshake with backpressure, so it can sit directly in datapaths whose clock target rules out a full-width carry chain.

Parameters:
PARALLELISM, 32, operand/result width in bits; must be divisible by NUM_STAGES.
NUM_STAGES, 4, pipeline depth; each stage adds PARALLELISM/NUM_STAGES bits; must be >= 1.
ARCH_TYPE, 0, segment adder implementation: 0 = synthesiser choice, 1 = ripple-carry of full adders.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode presented
in_ready  output  1  block accepts operands this cycle
add1  input  PARALLELISM  operand A, unsigned bit vector
add0  input  PARALLELISM  operand B
carry_in  input  1  carry into bit 0; used only when sub=0
sub  input  1  0: A+B+carry_in; 1: A-B, computed as A+~B+1
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  PARALLELISM  result, modulo 2^PARALLELISM
carry_out  output  1  carry out of the MSB; for sub, 1 means no borrow
overflow  output  1  two's-complement signed overflow of the operation

Behaviour:
- Segment width W = PARALLELISM/NUM_STAGES. Stage k adds bits [k*W+W-1:k*W] using the carry registered from stage k-1. Stage 0 uses carry_in, or 1 when sub=1.
- Operand skew: upper, not-yet-used operand slices and already-computed lower sum slices travel with the pipeline. Every stage therefore holds a complete transaction.
- B is inverted at acceptance when sub=1.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall=1 the whole pipeline holds, including bubbles. Otherwise all stages advance together.
- Latency: exactly NUM_STAGES cycles from acceptance to out_valid when there is no stall. Throughput is 1 per cycle.
- NUM_STAGES=1 gives a single registered full-width add with latency 1.
- sum, carry_out and overflow remain stable while out_valid=1 and out_ready=0.
- When out_valid=0 the data outputs hold their last value and are don't-care.
- carry_out = carry out of bit PARALLELISM-1 of the final stage.
- overflow = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]), where B' is the possibly inverted B. It is computed in the final stage.
- Per-stage valid bits form a shift register advancing on ~stall. in_valid=0 on an advancing cycle inserts a bubble.
- Reset (async assert, sync deassert is the integrator's responsibility):
  - All stage valid bits = 0, out_valid = 0.
  - sum, carry_out and overflow reset to 0.
  - in_ready = 1 after reset.
  - Transactions in flight at reset are discarded, with no partial output.
- Outputs are in-order only. No transaction is ever dropped or duplicated under any out_ready pattern.
- Simultaneous output transfer and input accept in the same cycle is legal and must sustain full throughput.
- Illegal parameters (PARALLELISM % NUM_STAGES != 0, NUM_STAGES < 1) must cause an elaboration error.

Test Plan:
All scenarios use PARALLELISM=32, NUM_STAGES=4 unless stated.
1. Carry propagation: add1=0xFFFFFFFF, add0=0x00000001, carry_in=0, sub=0, out_ready=1 -> 4 cycles after accept: sum=0x00000000, carry_out=1, overflow=0.
2. Signed overflow: add1=0x7FFFFFFF, add0=0x00000001, sub=0 -> sum=0x80000000, carry_out=0, overflow=1. Then 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, carry_out=1, overflow=1.
3. Subtract with borrow: add1=5, add0=7, sub=1, carry_in=1 (ignored) -> sum=0xFFFFFFFE, carry_out=0, overflow=0. Then 7-5 -> sum=2, carry_out=1.
4. Backpressure: 8 back-to-back random transactions; out_ready held low cycles 5-8 -> in_ready low exactly while stalled, outputs stable during the stall, all 8 results correct and in order against a reference model.
5. Reset mid-operation: 3 transactions accepted, rst_n pulsed low one cycle later -> out_valid=0 immediately, sum=0, carry_out=0, overflow=0, no stale result ever appears; the next accepted transaction returns correctly after 4 cycles.
6. Configuration sweep: NUM_STAGES=1 and NUM_STAGES=8 with ARCH_TYPE=0 and 1, 1000 random operations with random in_valid/out_ready -> latency 1 and 8 respectively, all results match the reference model.
